sram256x8_ctrl: RTL and testbench

SRAM256X8_CTRL -- requirements
Module: sram256x8_ctrl

---
 rtl/sram256x8_ctrl.sv | 157 +++++++++++++++
 tb/tb_sram256x8_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram256x8_ctrl.sv
// Request/response controller for a 256x8 synchronous SRAM macro strobed on sram_CE rising edge.
// Optional power-up init sweep of INIT_VALUE to all addresses: define SRAM256X8_CTRL_INIT_EN.
module sram256x8_ctrl #(
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic [7:0] sram_A,
    output logic       sram_CE,
    output logic       sram_WEB,
    output logic       sram_OEB,
    output logic       sram_CSB,
    output logic [7:0] sram_I,
    input  logic [7:0] sram_O
);

`ifdef SRAM256X8_CTRL_INIT_EN
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, CAPTURE, RESP, INIT_SETUP, INIT_STROBE
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, CAPTURE, RESP
    } state_t;
`endif

    state_t     state_q;
    logic       write_q;
    logic       ready_q;
    logic       resp_valid_q;
    logic [7:0] rdata_q;
    logic [7:0] a_q;
    logic [7:0] i_q;
    logic       ce_q;
    logic       csb_q;
    logic       web_q;
    logic       oeb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            write_q      <= 1'b0;
            ce_q         <= 1'b0;
            oeb_q        <= 1'b1;
            a_q          <= '0;
`ifdef SRAM256X8_CTRL_INIT_EN
            // Pin registers preload the first sweep SETUP; outputs are masked while reset is high.
            state_q      <= INIT_SETUP;
            ready_q      <= 1'b0;
            i_q          <= INIT_VALUE;
            csb_q        <= 1'b0;
            web_q        <= 1'b0;
`else
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            i_q          <= '0;
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= SETUP;
                        ready_q <= 1'b0;
                        write_q <= req_write;
                        a_q     <= req_addr;
                        i_q     <= req_wdata;
                        csb_q   <= 1'b0;
                        web_q   <= ~req_write;
                        ce_q    <= 1'b0;
                        oeb_q   <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    ce_q    <= 1'b1;
                end
                STROBE: begin
                    ce_q <= 1'b0;
                    if (write_q) begin
                        state_q      <= RESP;
                        csb_q        <= 1'b1;
                        web_q        <= 1'b1;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= '0;
                    end else begin
                        state_q <= CAPTURE;
                        oeb_q   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    state_q      <= RESP;
                    rdata_q      <= sram_O;
                    oeb_q        <= 1'b1;
                    csb_q        <= 1'b1;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end
                end
`ifdef SRAM256X8_CTRL_INIT_EN
                INIT_SETUP: begin
                    state_q <= INIT_STROBE;
                    ce_q    <= 1'b1;
                end
                INIT_STROBE: begin
                    ce_q <= 1'b0;
                    if (a_q == 8'hFF) begin
                        state_q <= IDLE;
                        csb_q   <= 1'b1;
                        web_q   <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= INIT_SETUP;
                        a_q     <= a_q + 8'd1;
                    end
                end
`endif
                default: begin
                    state_q      <= IDLE;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b0;
                    ce_q         <= 1'b0;
                    csb_q        <= 1'b1;
                    web_q        <= 1'b1;
                    oeb_q        <= 1'b1;
                end
            endcase
        end
    end

    // Reset is synchronous to clock, so masking with it keeps the pins glitch-free.
    assign req_ready  = ready_q & ~reset;
    assign resp_valid = resp_valid_q & ~reset;
    assign resp_rdata = reset ? 8'h00 : rdata_q;
    assign sram_A     = reset ? 8'h00 : a_q;
    assign sram_I     = reset ? 8'h00 : i_q;
    assign sram_CE    = ce_q & ~reset;
    assign sram_CSB   = csb_q | reset;
    assign sram_WEB   = web_q | reset;
    assign sram_OEB   = oeb_q | reset;

endmodule

// File: tb/tb_sram256x8_ctrl.sv
// Self-checking bench for sram256x8_ctrl: behavioural SRAM device, flat memory reference model,
// randomized traffic; build with SRAM256X8_CTRL_INIT_EN to exercise the init sweep.
module tb_sram256x8_ctrl;

`ifdef SRAM256X8_CTRL_INIT_EN
    localparam logic [7:0] INIT_V    = 8'h5A;
    localparam int         READY_LAT = 512;
    localparam bit         HAS_INIT  = 1'b1;
`else
    localparam logic [7:0] INIT_V    = 8'h00;
    localparam int         READY_LAT = 0;
    localparam bit         HAS_INIT  = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_rdata;
    logic [7:0] sram_A;
    logic       sram_CE;
    logic       sram_WEB;
    logic       sram_OEB;
    logic       sram_CSB;
    logic [7:0] sram_I;
    logic [7:0] sram_O;

    always #5 clock = ~clock;

    sram256x8_ctrl #(.INIT_VALUE(INIT_V)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sram_A(sram_A), .sram_CE(sram_CE), .sram_WEB(sram_WEB), .sram_OEB(sram_OEB),
        .sram_CSB(sram_CSB), .sram_I(sram_I), .sram_O(sram_O)
    );

    // Behavioural SRAM macro: acts on the rising edge of CE when selected.
    logic [7:0] sram_mem [256];
    bit         sram_wr  [256];
    logic [7:0] sram_rd = 8'h00;
    int         ce_rises = 0;

    always @(posedge sram_CE) begin
        ce_rises = ce_rises + 1;
        if (!sram_CSB) begin
            if (!sram_WEB) begin
                sram_mem[sram_A] = sram_I;
                sram_wr[sram_A]  = 1'b1;
            end else begin
                sram_rd = sram_wr[sram_A] ? sram_mem[sram_A] : 8'($urandom);
            end
        end
    end

    assign sram_O = sram_OEB ? 8'h00 : sram_rd;

    // Reference model: contents the controller should have stored.
    logic [7:0] model_mem   [256];
    bit         model_known [256];
    int         n_checks = 0;
    int         n_fails  = 0;

    task automatic model_reset();
        if (HAS_INIT) begin
            for (int i = 0; i < 256; i++) begin
                model_mem[i]   = INIT_V;
                model_known[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_ready_after_reset(output int n);
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 1000) begin
            n++;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one request and collects latency, read data and hold stability.
    task automatic run_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int stall, output int lat, output logic [7:0] rd,
                           output bit stable);
        int n;
        lat = -1; rd = 8'hxx; stable = 1'b1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 2000) begin
            n++;
            @(negedge clock);
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            @(posedge clock); #1;
            return;
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (wr) begin
            model_mem[addr]   = wdata;
            model_known[addr] = 1'b1;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            @(posedge clock); #1;
            return;
        end
        rd = resp_rdata;
        repeat (stall) begin
            @(negedge clock);
            if (!resp_valid || resp_rdata !== rd || req_ready) stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (2) begin @(posedge clock); #1; end
        @(negedge clock);
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, sram_A, sram_I, sram_CE, sram_CSB, sram_WEB, sram_OEB}
            !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_fails++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h A=%h I=%h CE=%b CSB=%b WEB=%b OEB=%b",
                     req_ready, resp_valid, resp_rdata, sram_A, sram_I, sram_CE, sram_CSB,
                     sram_WEB, sram_OEB);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        wait_ready_after_reset(n);
        n_checks++;
        if (n !== READY_LAT) begin
            n_fails++;
            $display("FAIL ready_latency: got %0d cycles expected %0d", n, READY_LAT);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [7:0] rd; bit st;
        run_req(1'b1, 8'h3C, 8'hA5, 0, lat, rd, st);
        n_checks++;
        if (lat !== 3 || rd !== 8'h00) begin
            n_fails++;
            $display("FAIL write_resp: lat=%0d rdata=%h expected lat=3 rdata=00", lat, rd);
        end
        run_req(1'b0, 8'h3C, 8'h00, 0, lat, rd, st);
        n_checks++;
        if (lat !== 4 || rd !== model_mem[8'h3C]) begin
            n_fails++;
            $display("FAIL read_resp: lat=%0d rdata=%h expected lat=4 rdata=%h", lat, rd,
                     model_mem[8'h3C]);
        end
    endtask

    task automatic test_stall();
        int lat; logic [7:0] rd; bit st;
        logic [7:0] d;
        d = 8'($urandom);
        run_req(1'b1, 8'h21, d, 0, lat, rd, st);
        run_req(1'b0, 8'h21, 8'h00, 5, lat, rd, st);
        n_checks++;
        if (!st || rd !== d || lat !== 4) begin
            n_fails++;
            $display("FAIL stall_hold: stable=%b rdata=%h lat=%0d expected stable=1 rdata=%h lat=4",
                     st, rd, lat, d);
        end
        @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL after_handshake: req_ready=%b resp_valid=%b expected 1 0",
                     req_ready, resp_valid);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_boundary();
        int lat; logic [7:0] rd; bit st;
        logic [7:0] d0;
        d0 = 8'($urandom);
        run_req(1'b1, 8'h00, d0, 0, lat, rd, st);
        run_req(1'b1, 8'hFF, ~d0, 0, lat, rd, st);
        run_req(1'b0, 8'h00, 8'h00, 0, lat, rd, st);
        n_checks++;
        if (rd !== d0) begin
            n_fails++;
            $display("FAIL addr_00: rdata=%h expected %h", rd, d0);
        end
        run_req(1'b0, 8'hFF, 8'h00, 1, lat, rd, st);
        n_checks++;
        if (rd !== ~d0) begin
            n_fails++;
            $display("FAIL addr_FF: rdata=%h expected %h", rd, ~d0);
        end
    endtask

    task automatic test_reset_abort();
        int lat, n, ce0; logic [7:0] rd; bit st;
        run_req(1'b1, 8'h10, 8'h11, 0, lat, rd, st);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hEE;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 2000) begin
            n++;
            @(negedge clock);
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        ce0 = ce_rises;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (sram_CE !== 1'b0 || sram_CSB !== 1'b1) begin
            n_fails++;
            $display("FAIL abort_pins: CE=%b CSB=%b expected 0 1", sram_CE, sram_CSB);
        end
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        model_reset();
        n_checks++;
        if (ce_rises !== ce0 || resp_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_no_strobe: ce_rises=%0d resp_valid=%b expected %0d 0",
                     ce_rises, resp_valid, ce0);
        end
        run_req(1'b0, 8'h10, 8'h00, 0, lat, rd, st);
        n_checks++;
        if (rd !== model_mem[8'h10]) begin
            n_fails++;
            $display("FAIL abort_data: rdata=%h expected %h", rd, model_mem[8'h10]);
        end
    endtask

    task automatic test_init();
        int lat, n; logic [7:0] rd; bit st;
        reset = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;
        model_reset();
        wait_ready_after_reset(n);
        n_checks++;
        if (n !== READY_LAT) begin
            n_fails++;
            $display("FAIL init_ready: got %0d cycles expected %0d", n, READY_LAT);
        end
        if (HAS_INIT) begin
            run_req(1'b0, 8'h80, 8'h00, 0, lat, rd, st);
            n_checks++;
            if (rd !== INIT_V || lat !== 4) begin
                n_fails++;
                $display("FAIL init_data: rdata=%h lat=%0d expected %h 4", rd, lat, INIT_V);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [7:0] rd; bit st;
        logic wr; logic [7:0] a, d, exp_rd; int stall, exp_lat;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom);
            a  = 8'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (!model_known[a]) wr = 1'b1;
            exp_rd  = wr ? 8'h00 : model_mem[a];
            exp_lat = wr ? 3 : 4;
            stall   = $urandom_range(0, 2);
            run_req(wr, a, d, stall, lat, rd, st);
            n_checks++;
            if (lat !== exp_lat || rd !== exp_rd || !st) begin
                n_fails++;
                $display("FAIL random_%0d: wr=%b addr=%h lat=%0d rdata=%h stable=%b expected lat=%0d rdata=%h",
                         t, wr, a, lat, rd, st, exp_lat, exp_rd);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i]   = 8'h00;
            model_known[i] = 1'b0;
        end
        fork
            forever begin
                @(negedge clock);
                n_checks++;
                if (!sram_OEB && (sram_CE || !sram_WEB)) begin
                    n_fails++;
                    $display("FAIL oeb_overlap: OEB=%b CE=%b WEB=%b expected no OEB=0 with CE=1 or WEB=0",
                             sram_OEB, sram_CE, sram_WEB);
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
                $fatal(1, "timeout");
            end
        join_none
        test_reset();
        test_write_read();
        test_stall();
        test_boundary();
        test_reset_abort();
        test_init();
        test_random();
        apply_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
